// File: rtl/l3fwd_axil_csr_if.sv
// AXI-Lite bus bundle between the SoC master port and the l3fwd CSR block.
interface l3fwd_axil_csr_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/l3fwd_axil_csr.sv
// l3fwd control/status registers on AXI-Lite, with an indirect engine that turns a
// CPU command into one forwarding-table read or write on a valid/ready port.
module l3fwd_axil_csr #(
    parameter int AXIL_ADDR_WIDTH = 24,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
    parameter int TBL_ADDR_WIDTH  = 10,
    parameter int TBL_DATA_WIDTH  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    l3fwd_axil_csr_if.slave           s_axil,
    output logic                      ctrl_enable,
    input  logic                      stat_pkt,
    output logic [TBL_ADDR_WIDTH-1:0] m_tbl_addr,
    output logic [TBL_DATA_WIDTH-1:0] m_tbl_wdata,
    output logic                      m_tbl_we,
    output logic                      m_tbl_valid,
    input  logic                      m_tbl_ready,
    input  logic [TBL_DATA_WIDTH-1:0] s_tbl_rdata,
    input  logic                      s_tbl_rvalid
);
    localparam logic [5:0]  REG_ID     = 6'h00;
    localparam logic [5:0]  REG_CTRL   = 6'h01;
    localparam logic [5:0]  REG_TADDR  = 6'h02;
    localparam logic [5:0]  REG_TCMD   = 6'h03;
    localparam logic [5:0]  REG_DLO    = 6'h04;
    localparam logic [5:0]  REG_DHI    = 6'h05;
    localparam logic [5:0]  REG_STATUS = 6'h06;
    localparam logic [5:0]  REG_PKT    = 6'h07;
    localparam logic [31:0] ID_VALUE   = 32'h4C33_4657;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_DEC   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    function automatic logic [31:0] merge_strb(input logic [31:0] cur, input logic [31:0] nxt,
                                               input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = strb[b] ? nxt[8*b +: 8] : cur[8*b +: 8];
        return res;
    endfunction

    state_t                    state, state_next;
    logic                      busy;
    logic                      aw_held, w_held;
    logic [5:0]                aw_idx_q;
    logic [31:0]               wdata_q;
    logic [3:0]                wstrb_q;
    logic                      bvalid_r, rvalid_r;
    logic [1:0]                bresp_r, rresp_r;
    logic [31:0]               rdata_r;
    logic [TBL_ADDR_WIDTH-1:0] tbl_addr_r, taddr_next;
    logic [31:0]               data_lo, data_hi, pkt_cnt;
    logic                      cmd_err;
    logic [TBL_ADDR_WIDTH-1:0] cmd_addr_q;
    logic [TBL_DATA_WIDTH-1:0] cmd_wdata_q;
    logic                      cmd_we_q;

    logic                      aw_hs, w_hs, ar_hs, wr_go, wr_err;
    logic [5:0]                wr_idx;
    logic [31:0]               wr_data;
    logic [3:0]                wr_strb;
    logic                      cnt_clr, tbl_cmd_wr, cmd_accept, cmd_reject, rd_capture;
    logic [31:0]               rd_val;
    logic                      rd_err;

    assign s_axil.awready = !aw_held && !bvalid_r;
    assign s_axil.wready  = !w_held && !bvalid_r;
    assign s_axil.arready = !rvalid_r;
    assign s_axil.bvalid  = bvalid_r;
    assign s_axil.bresp   = bresp_r;
    assign s_axil.rvalid  = rvalid_r;
    assign s_axil.rresp   = rresp_r;
    assign s_axil.rdata   = rdata_r;

    assign aw_hs = s_axil.awvalid && s_axil.awready;
    assign w_hs  = s_axil.wvalid && s_axil.wready;
    assign ar_hs = s_axil.arvalid && s_axil.arready;

    // A held half comes from its holding register, a fresh one straight off the bus.
    assign wr_idx  = aw_held ? aw_idx_q : s_axil.awaddr[7:2];
    assign wr_data = w_held ? wdata_q : s_axil.wdata;
    assign wr_strb = w_held ? wstrb_q : s_axil.wstrb;
    assign wr_go   = (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_err  = (wr_idx[5:3] != 3'b000);

    assign cnt_clr    = wr_go && (wr_idx == REG_CTRL) && wr_strb[0] && wr_data[1];
    assign tbl_cmd_wr = wr_go && (wr_idx == REG_TCMD) && wr_strb[0];
    assign cmd_accept = tbl_cmd_wr && (state == S_IDLE) && (wr_data[1:0] == 2'b01 || wr_data[1:0] == 2'b10);
    assign cmd_reject = tbl_cmd_wr && !cmd_accept;
    assign rd_capture = (state == S_WAIT) && s_tbl_rvalid;

    always_comb begin
        taddr_next = tbl_addr_r;
        for (int i = 0; i < TBL_ADDR_WIDTH; i++)
            if (wr_strb[i/8]) taddr_next[i] = wr_data[i];
    end

    always_comb begin
        rd_val = 32'h0;
        rd_err = 1'b0;
        case (s_axil.araddr[7:2])
            REG_ID:     rd_val = ID_VALUE;
            REG_CTRL:   rd_val = {31'h0, ctrl_enable};
            REG_TADDR:  rd_val = 32'(tbl_addr_r);
            REG_TCMD:   rd_val = 32'h0;
            REG_DLO:    rd_val = data_lo;
            REG_DHI:    rd_val = data_hi;
            REG_STATUS: rd_val = {30'h0, cmd_err, busy};
            REG_PKT:    rd_val = pkt_cnt;
            default:    rd_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (cmd_accept)   state_next = S_REQ;
            S_REQ:  if (m_tbl_ready)  state_next = cmd_we_q ? S_IDLE : S_WAIT;
            S_WAIT: if (s_tbl_rvalid) state_next = S_IDLE;
            default:                  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        m_tbl_valid = (state == S_REQ);
        busy        = (state != S_IDLE);
    end

    assign m_tbl_addr  = cmd_addr_q;
    assign m_tbl_wdata = cmd_wdata_q;
    assign m_tbl_we    = cmd_we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_idx_q    <= 6'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            bvalid_r    <= 1'b0;
            bresp_r     <= RESP_OKAY;
            rvalid_r    <= 1'b0;
            rresp_r     <= RESP_OKAY;
            rdata_r     <= 32'h0;
            ctrl_enable <= 1'b0;
            tbl_addr_r  <= '0;
            data_lo     <= 32'h0;
            data_hi     <= 32'h0;
            cmd_err     <= 1'b0;
            pkt_cnt     <= 32'h0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_we_q    <= 1'b0;
        end else begin
            if (wr_go) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_r <= 1'b1;
                bresp_r  <= wr_err ? RESP_DEC : RESP_OKAY;
                case (wr_idx)
                    REG_CTRL:   if (wr_strb[0]) ctrl_enable <= wr_data[0];
                    REG_TADDR:  tbl_addr_r <= taddr_next;
                    REG_DLO:    data_lo <= merge_strb(data_lo, wr_data, wr_strb);
                    REG_DHI:    data_hi <= merge_strb(data_hi, wr_data, wr_strb);
                    REG_STATUS: if (wr_strb[0] && wr_data[1]) cmd_err <= 1'b0;
                    default: ;
                endcase
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= s_axil.awaddr[7:2];
                end
                if (w_hs) begin
                    w_held  <= 1'b1;
                    wdata_q <= s_axil.wdata;
                    wstrb_q <= s_axil.wstrb;
                end
            end
            if (bvalid_r && s_axil.bready) bvalid_r <= 1'b0;

            if (cmd_reject) cmd_err <= 1'b1;
            if (cmd_accept) begin
                cmd_addr_q  <= tbl_addr_r;
                cmd_wdata_q <= {data_hi, data_lo};
                cmd_we_q    <= wr_data[0];
            end
            // Returned table data wins over a CPU write to the data words in the same cycle.
            if (rd_capture) begin
                data_lo <= s_tbl_rdata[31:0];
                data_hi <= s_tbl_rdata[TBL_DATA_WIDTH-1:32];
            end

            if (cnt_clr)       pkt_cnt <= 32'h0;
            else if (stat_pkt) pkt_cnt <= pkt_cnt + 32'h1;

            if (ar_hs) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_val;
                rresp_r  <= rd_err ? RESP_DEC : RESP_OKAY;
            end else if (rvalid_r && s_axil.rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s_axil.awprot, s_axil.arprot,
                           s_axil.awaddr[AXIL_ADDR_WIDTH-1:8], s_axil.awaddr[1:0],
                           s_axil.araddr[AXIL_ADDR_WIDTH-1:8], s_axil.araddr[1:0]};
endmodule

// File: tb/tb_l3fwd_axil_csr.sv
// Directed bench for l3fwd_axil_csr: register map, write/read channel timing, table engine, counter, reset.
module tb_l3fwd_axil_csr;
    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_enable;
    logic        stat_pkt;
    logic [9:0]  m_tbl_addr;
    logic [63:0] m_tbl_wdata;
    logic        m_tbl_we, m_tbl_valid, m_tbl_ready;
    logic [63:0] s_tbl_rdata;
    logic        s_tbl_rvalid;

    int n_checks = 0;
    int n_errors = 0;

    l3fwd_axil_csr_if #(.ADDR_W(24), .DATA_W(32)) axil ();

    l3fwd_axil_csr #(
        .AXIL_ADDR_WIDTH(24), .AXIL_DATA_WIDTH(32), .TBL_ADDR_WIDTH(10), .TBL_DATA_WIDTH(64)
    ) dut (
        .clk(clk), .rst(rst), .s_axil(axil), .ctrl_enable(ctrl_enable), .stat_pkt(stat_pkt),
        .m_tbl_addr(m_tbl_addr), .m_tbl_wdata(m_tbl_wdata), .m_tbl_we(m_tbl_we),
        .m_tbl_valid(m_tbl_valid), .m_tbl_ready(m_tbl_ready),
        .s_tbl_rdata(s_tbl_rdata), .s_tbl_rvalid(s_tbl_rvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axil_write(input logic [23:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [1:0] resp);
        logic aw_done, w_done, aw_rdy, w_rdy, got_b;
        int cyc;
        axil.awaddr = addr; axil.awprot = 3'b0; axil.awvalid = 1'b1;
        axil.wdata = data;  axil.wstrb = strb;  axil.wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            aw_rdy = axil.awready;
            w_rdy  = axil.wready;
            @(posedge clk); #1;
            if (aw_rdy && axil.awvalid) begin aw_done = 1'b1; axil.awvalid = 1'b0; end
            if (w_rdy && axil.wvalid)   begin w_done = 1'b1;  axil.wvalid = 1'b0;  end
            cyc++;
        end
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        check("wr_accept", {62'b0, aw_done, w_done}, 64'h3);
        axil.bready = 1'b1; cyc = 0;
        while (!axil.bvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        got_b = axil.bvalid;
        resp  = axil.bresp;
        @(posedge clk); #1;
        axil.bready = 1'b0;
        check("wr_bvalid", {63'b0, got_b}, 64'h1);
    endtask

    task automatic axil_read(input logic [23:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        logic got_r;
        axil.araddr = addr; axil.arprot = 3'b0; axil.arvalid = 1'b1; cyc = 0;
        while (!axil.arready && cyc < 50) begin @(posedge clk); #1; cyc++; end
        @(posedge clk); #1;
        axil.arvalid = 1'b0; axil.rready = 1'b1; cyc = 0;
        while (!axil.rvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        got_r = axil.rvalid;
        data  = axil.rdata;
        resp  = axil.rresp;
        @(posedge clk); #1;
        axil.rready = 1'b0;
        check("rd_rvalid", {63'b0, got_r}, 64'h1);
    endtask

    task automatic wr(input logic [23:0] addr, input logic [31:0] data);
        logic [1:0] resp;
        axil_write(addr, data, 4'hF, resp);
        check("wr_bresp", 64'(resp), 64'h0);
    endtask

    task automatic rd_check(input string tag, input logic [23:0] addr, input logic [31:0] exp);
        logic [31:0] data;
        logic [1:0]  resp;
        axil_read(addr, data, resp);
        check(tag, 64'(data), 64'(exp));
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        rst = 1'b1; stat_pkt = 1'b0; m_tbl_ready = 1'b0; s_tbl_rdata = 64'h0; s_tbl_rvalid = 1'b0;
        axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b0;
        axil.wdata = '0;  axil.wstrb = '0;  axil.wvalid = 1'b0; axil.bready = 1'b0;
        axil.araddr = '0; axil.arprot = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state and ID/CTRL readback
        check("rst_awready", 64'(axil.awready), 64'h1);
        check("rst_wready", 64'(axil.wready), 64'h1);
        check("rst_arready", 64'(axil.arready), 64'h1);
        check("rst_bvalid", 64'(axil.bvalid), 64'h0);
        check("rst_tbl_valid", 64'(m_tbl_valid), 64'h0);
        check("rst_enable", 64'(ctrl_enable), 64'h0);
        axil_read(24'h00, d, r);
        check("id_data", 64'(d), 64'h4C334657);
        check("id_resp", 64'(r), 64'h0);
        rd_check("ctrl_rst", 24'h04, 32'h0);

        // W leads AW by 3 cycles, bready held off for 5 cycles
        axil.wdata = 32'h1; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
        @(posedge clk); #1;
        axil.wvalid = 1'b0;
        check("w_held_wready", 64'(axil.wready), 64'h0);
        repeat (2) @(posedge clk); #1;
        check("w_only_enable", 64'(ctrl_enable), 64'h0);
        axil.awaddr = 24'h04; axil.awvalid = 1'b1;
        @(posedge clk); #1;
        axil.awvalid = 1'b0;
        check("late_aw_enable", 64'(ctrl_enable), 64'h1);
        for (int i = 0; i < 5; i++) begin
            check("b_hold_bvalid", 64'(axil.bvalid), 64'h1);
            check("b_hold_awready", 64'(axil.awready), 64'h0);
            @(posedge clk); #1;
        end
        check("b_hold_bresp", 64'(axil.bresp), 64'h0);
        axil.bready = 1'b1;
        @(posedge clk); #1;
        axil.bready = 1'b0;
        check("b_done_bvalid", 64'(axil.bvalid), 64'h0);
        check("b_done_awready", 64'(axil.awready), 64'h1);

        // RO register ignores writes
        wr(24'h00, 32'h0);
        rd_check("id_after_wr", 24'h00, 32'h4C334657);

        // table write command with a stalled table port
        wr(24'h08, 32'h2A);
        wr(24'h10, 32'h11223344);
        wr(24'h14, 32'h55667788);
        wr(24'h0C, 32'h1);
        check("twr_valid", 64'(m_tbl_valid), 64'h1);
        check("twr_addr", 64'(m_tbl_addr), 64'h2A);
        check("twr_wdata", m_tbl_wdata, 64'h5566778811223344);
        check("twr_we", 64'(m_tbl_we), 64'h1);
        rd_check("twr_busy", 24'h18, 32'h1);
        check("twr_valid_held", 64'(m_tbl_valid), 64'h1);
        m_tbl_ready = 1'b1;
        @(posedge clk); #1;
        m_tbl_ready = 1'b0;
        check("twr_valid_drop", 64'(m_tbl_valid), 64'h0);
        rd_check("twr_idle", 24'h18, 32'h0);

        // table read command, second command while waiting
        m_tbl_ready = 1'b1;
        wr(24'h08, 32'h3);
        wr(24'h0C, 32'h2);
        check("trd_we", 64'(m_tbl_we), 64'h0);
        check("trd_addr", 64'(m_tbl_addr), 64'h3);
        check("trd_valid_gone", 64'(m_tbl_valid), 64'h0);
        wr(24'h0C, 32'h2);
        rd_check("trd_busy_err", 24'h18, 32'h3);
        s_tbl_rdata = 64'hDEADBEEF_CAFEF00D; s_tbl_rvalid = 1'b1;
        @(posedge clk); #1;
        s_tbl_rvalid = 1'b0;
        rd_check("trd_lo", 24'h10, 32'hCAFEF00D);
        rd_check("trd_hi", 24'h14, 32'hDEADBEEF);
        rd_check("trd_err_sticky", 24'h18, 32'h2);
        wr(24'h18, 32'h2);
        rd_check("err_cleared", 24'h18, 32'h0);
        wr(24'h0C, 32'h3);
        rd_check("go11_err", 24'h18, 32'h2);
        wr(24'h18, 32'h2);
        axil_write(24'h10, 32'h11223344, 4'b0011, r);
        rd_check("strb_lo", 24'h10, 32'hCAFE3344);

        // packet counter and clear with a coincident pulse
        stat_pkt = 1'b1;
        repeat (10) @(posedge clk); #1;
        stat_pkt = 1'b0;
        rd_check("pkt_10", 24'h1C, 32'd10);
        axil.awaddr = 24'h04; axil.wdata = 32'h2; axil.wstrb = 4'hF;
        axil.awvalid = 1'b1; axil.wvalid = 1'b1; stat_pkt = 1'b1;
        @(posedge clk); #1;
        axil.awvalid = 1'b0; axil.wvalid = 1'b0; stat_pkt = 1'b0;
        check("clr_bvalid", 64'(axil.bvalid), 64'h1);
        axil.bready = 1'b1;
        @(posedge clk); #1;
        axil.bready = 1'b0;
        rd_check("pkt_cleared", 24'h1C, 32'h0);
        rd_check("ctrl_clr_reads0", 24'h04, 32'h0);
        check("clr_enable", 64'(ctrl_enable), 64'h0);

        // decode error and reset during WAIT
        axil_read(24'h40, d, r);
        check("dec_rdata", 64'(d), 64'h0);
        check("dec_rresp", 64'(r), 64'h3);
        axil_write(24'h40, 32'hFFFF_FFFF, 4'hF, r);
        check("dec_bresp", 64'(r), 64'h3);
        wr(24'h04, 32'h1);
        wr(24'h08, 32'h5);
        wr(24'h0C, 32'h2);
        rd_check("wait_busy", 24'h18, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_enable", 64'(ctrl_enable), 64'h0);
        check("mid_rst_valid", 64'(m_tbl_valid), 64'h0);
        check("mid_rst_arready", 64'(axil.arready), 64'h1);
        check("mid_rst_bvalid", 64'(axil.bvalid), 64'h0);
        rd_check("mid_rst_status", 24'h18, 32'h0);
        s_tbl_rdata = 64'h0123456789ABCDEF; s_tbl_rvalid = 1'b1;
        @(posedge clk); #1;
        s_tbl_rvalid = 1'b0;
        rd_check("late_rvalid_lo", 24'h10, 32'h0);
        rd_check("late_rvalid_hi", 24'h14, 32'h0);
        rd_check("rst_taddr", 24'h08, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
